prom_arbiter: RTL
=================

PROM_ARBITER -- requirements
Module: prom_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 16, PROM address width.
- DATA_W, default 8, pixel width.
- RD_LAT, default 2, cycles from PROM ce cycle to valid prom_dout.
- LAST_ADDR, default 50624, highest legal image address.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 i_vsync  in  1  active-low frame sync.
REQ-005 req0 / req1  in  1  read request, requester 0 (filter loader) / 1 (raw overlay path).
REQ-006 addr0 / addr1  in  ADDR_W  request address, sampled only while matching req is high.
REQ-007 urgent0  in  1  requester 0 line buffer near starvation; raises priority.
REQ-008 gnt0 / gnt1  out  1  combinational grant, same cycle as request.
REQ-009 rvalid0 / rvalid1  out  1  read data valid for that requester.
REQ-010 rdata  out  DATA_W  shared read data, equal to prom_dout, qualified by rvalidN.
REQ-011 err0 / err1  out  1  one-cycle pulse on out-of-range request.
REQ-012 prom_ce  out  1  PROM clock enable.
REQ-013 prom_addr  out  ADDR_W  PROM address.
REQ-014 prom_dout  in  DATA_W  PROM data.
REQ-015 conflict_cnt  out  16  saturating count of cycles with both requests high, per frame.

Function
REQ-016 At most one of gnt0/gnt1 SHALL be high per cycle; a requester is granted only while its req is high.
REQ-017 Arbitration order:
- i_vsync low: no grant.
- urgent0 and req0 both high: grant 0.
- Single requester: grant it.
- Both requesting: grant the requester not granted most recently (round-robin pointer).
REQ-018 The round-robin pointer SHALL update only on a grant and SHALL be unaffected by urgent0 except through that grant.
REQ-019 Legal grant (addr ≤ LAST_ADDR): prom_ce=1 and prom_addr=granted address in the same cycle.
REQ-020 Otherwise prom_ce=0 and prom_addr SHALL hold its last value.
REQ-021 Out-of-range grant (addr > LAST_ADDR):
- gnt asserted (request consumed), prom_ce=0.
- errN pulses exactly one cycle later.
- No rvalid is produced.
REQ-022 An RD_LAT-deep tag pipeline (valid bit + owner bit) SHALL track every legal grant.
REQ-023 rvalidN SHALL be asserted exactly RD_LAT cycles after the granting cycle, for exactly one cycle, to the owner only.
REQ-024 Back-to-back grants SHALL be accepted every cycle (full throughput) with in-order returns.
REQ-025 i_vsync low SHALL, on each clock edge while low:
- Clear the tag pipeline; no rvalid emerges for in-flight reads.
- Reset the round-robin pointer so requester 0 wins the next tie.
- Clear conflict_cnt.
REQ-026 conflict_cnt SHALL increment on every cycle with req0 and req1 both high and i_vsync high, saturating at 16'hFFFF.
REQ-027 rdata SHALL be combinationally prom_dout; no additional register stage.

Reset
REQ-028 While rst is high at a clock edge:
- Outputs: rvalid0/1=0, err0/1=0, prom_addr=0, conflict_cnt=0.
- Tag pipeline cleared; round-robin pointer favours requester 0.
REQ-029 gnt0/gnt1/prom_ce SHALL be forced 0 while rst is high.
REQ-030 Reset mid-burst SHALL discard all in-flight reads with no later rvalid.

Verification
REQ-031 req0=1 addr0=10 alone at cycle T -> gnt0=1, prom_ce=1, prom_addr=10 at T; rvalid0=1 with rdata=PROM[10] at T+2; rvalid1 stays 0.
REQ-032 req0 and req1 held high 6 cycles, urgent0=0, fresh after vsync -> grants alternate 0,1,0,1,0,1; rvalids alternate with 2-cycle lag; conflict_cnt=6.
REQ-033 Both high with urgent0=1 for 4 cycles -> gnt0 all 4 cycles, gnt1 never; after urgent0 drops, the next tie grants requester 1.
REQ-034 req1 with addr1=50625 -> gnt1=1, prom_ce=0 that cycle, err1 pulse next cycle, no rvalid1.
REQ-035 Two legal grants, then i_vsync low for 1 cycle before their return -> neither rvalid asserted, conflict_cnt=0, next tie grants 0.
REQ-036 rst asserted 1 cycle after a grant -> no rvalid ever for that read; all outputs at reset values on the following cycle.

Source files
------------

// File: rtl/prom_arbiter.sv
// Two-requester PROM read arbiter: urgent/round-robin grant, range check, and an
// RD_LAT-deep tag pipeline steering the shared PROM data back to the owner.
module prom_arbiter #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned LAST_ADDR = 50624
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vsync,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              urgent0,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              err0,
    output logic              err1,
    output logic              prom_ce,
    output logic [ADDR_W-1:0] prom_addr,
    input  logic [DATA_W-1:0] prom_dout,
    output logic [15:0]       conflict_cnt
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(LAST_ADDR);

    logic              any_gnt;
    logic              sel1;
    logic              legal;
    logic [ADDR_W-1:0] gnt_addr;

    logic              last_q;     // 1: requester 1 was granted most recently
    logic [ADDR_W-1:0] addr_q;
    logic              err0_q;
    logic              err1_q;
    logic [15:0]       cnt_q;
    logic [RD_LAT-1:0] tag_vld_q;
    logic [RD_LAT-1:0] tag_own_q;

    always_comb begin
        any_gnt = 1'b0;
        sel1    = 1'b0;
        if (!rst && i_vsync) begin
            if (urgent0 && req0) begin
                any_gnt = 1'b1;
                sel1    = 1'b0;
            end else if (req0 && req1) begin
                any_gnt = 1'b1;
                sel1    = ~last_q;
            end else if (req0) begin
                any_gnt = 1'b1;
                sel1    = 1'b0;
            end else if (req1) begin
                any_gnt = 1'b1;
                sel1    = 1'b1;
            end
        end
    end

    assign gnt0      = any_gnt & ~sel1;
    assign gnt1      = any_gnt & sel1;
    assign gnt_addr  = sel1 ? addr1 : addr0;
    assign legal     = (gnt_addr <= LastAddr);
    assign prom_ce   = any_gnt & legal;
    assign prom_addr = prom_ce ? gnt_addr : addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= 1'b1;
            addr_q    <= '0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            cnt_q     <= '0;
            tag_vld_q <= '0;
        end else begin
            err0_q <= any_gnt & ~legal & ~sel1;
            err1_q <= any_gnt & ~legal & sel1;
            if (prom_ce) begin
                addr_q <= gnt_addr;
            end
            if (!i_vsync) begin
                tag_vld_q <= '0;
                last_q    <= 1'b1;
                cnt_q     <= '0;
            end else begin
                tag_vld_q[0] <= prom_ce;
                tag_own_q[0] <= sel1;
                for (int unsigned i = 1; i < RD_LAT; i++) begin
                    tag_vld_q[i] <= tag_vld_q[i-1];
                    tag_own_q[i] <= tag_own_q[i-1];
                end
                if (any_gnt) begin
                    last_q <= sel1;
                end
                if (req0 && req1 && cnt_q != 16'hFFFF) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end
    end

    // Gate returns with vsync so a read already at the pipe output is dropped in the frame-sync cycle.
    assign rvalid0      = i_vsync & tag_vld_q[RD_LAT-1] & ~tag_own_q[RD_LAT-1];
    assign rvalid1      = i_vsync & tag_vld_q[RD_LAT-1] & tag_own_q[RD_LAT-1];
    assign rdata        = prom_dout;
    assign err0         = err0_q;
    assign err1         = err1_q;
    assign conflict_cnt = cnt_q;

endmodule
